// File: rtl/uart_baud_gen_frac_if.sv
// Divisor configuration channel between the UART register file (master) and the
// baud generator (slave): valid/ready transfer plus a rejection pulse.
interface uart_baud_gen_frac_if #(
  parameter int unsigned WIDTH = 20
);
  logic             cfg_valid;
  logic [WIDTH-1:0] cfg_divisor;
  logic             cfg_ready;
  logic             cfg_err;

  modport master (
    output cfg_valid,
    output cfg_divisor,
    input  cfg_ready,
    input  cfg_err
  );

  modport slave (
    input  cfg_valid,
    input  cfg_divisor,
    output cfg_ready,
    output cfg_err
  );
endinterface

// File: rtl/uart_baud_gen_frac.sv
// Fractional UART baud tick generator: oversample, TX bit and RX mid-bit enable
// pulses derived from one down-counter with a fractional carry accumulator.
module uart_baud_gen_frac #(
  parameter int unsigned CLOCK_INPUT  = 50_000_000,
  parameter int unsigned DEFAULT_BAUD = 9600,
  parameter int unsigned OVERSAMPLING = 16,
  parameter int unsigned DIV_WIDTH    = 16,
  parameter int unsigned FRAC_BITS    = 4
) (
  input  logic                                clock,
  input  logic                                nreset,
  input  logic                                ena,
  uart_baud_gen_frac_if.slave                 cfg,
  input  logic                                rx_resync,
  output logic                                os_tick,
  output logic                                tx_bit_tick,
  output logic                                rx_sample_tick,
  output logic [$clog2(OVERSAMPLING)-1:0]     os_phase,
  output logic [DIV_WIDTH+FRAC_BITS-1:0]      divisor_out
);

  localparam int unsigned CFG_W = DIV_WIDTH + FRAC_BITS;
  localparam int unsigned PH_W  = $clog2(OVERSAMPLING);

  // Rounded fixed-point divisor for the reset baud rate
  localparam logic [63:0] DIV_NUM = 64'(CLOCK_INPUT) << FRAC_BITS;
  localparam logic [63:0] DIV_DEN = 64'(DEFAULT_BAUD) * 64'(OVERSAMPLING);
  localparam logic [63:0] DIV_RND = (64'd2 * DIV_NUM + DIV_DEN) / (64'd2 * DIV_DEN);
  localparam logic [CFG_W-1:0]     DEFAULT_DIV = DIV_RND[CFG_W-1:0];
  localparam logic [DIV_WIDTH-1:0] DEFAULT_INT = DEFAULT_DIV[CFG_W-1:FRAC_BITS];

  localparam logic [PH_W-1:0]      PH_LAST = PH_W'(OVERSAMPLING - 1);
  localparam logic [PH_W-1:0]      PH_MID  = PH_W'(OVERSAMPLING / 2 - 1);
  localparam logic [DIV_WIDTH-1:0] ONE     = DIV_WIDTH'(1);
  localparam logic [DIV_WIDTH-1:0] TWO     = DIV_WIDTH'(2);

  logic [DIV_WIDTH-1:0] base_cnt;
  logic [DIV_WIDTH-1:0] cur_int;
  logic [DIV_WIDTH-1:0] next_int;
  logic [DIV_WIDTH-1:0] reload_val;
  logic [FRAC_BITS-1:0] frac_acc;
  logic [FRAC_BITS-1:0] acc_sum;
  logic                 acc_carry;
  logic [PH_W-1:0]      rx_phase;
  logic [PH_W-1:0]      os_phase_n;
  logic [PH_W-1:0]      rx_phase_n;
  logic [CFG_W-1:0]     pend_div;
  logic [CFG_W-1:0]     next_div;
  logic                 pend_valid;
  logic                 tick_now;
  logic                 apply_now;
  logic                 cfg_fire;
  logic                 cfg_bad;

  // Phases advance one cycle after the visible os_tick, so the phase shown
  // alongside a tick is the one that tick belongs to.
  always_comb begin
    cur_int               = divisor_out[CFG_W-1:FRAC_BITS];
    {acc_carry, acc_sum}  = {1'b0, frac_acc} + {1'b0, divisor_out[FRAC_BITS-1:0]};
    reload_val            = cur_int - ONE + DIV_WIDTH'(acc_carry);
    tick_now              = ena && (base_cnt == '0);
    os_phase_n            = os_tick ? os_phase + 1'b1 : os_phase;
    rx_phase_n            = rx_resync ? '0 : (os_tick ? rx_phase + 1'b1 : rx_phase);
    cfg_fire              = cfg.cfg_valid && cfg.cfg_ready;
    cfg_bad               = cfg.cfg_divisor[CFG_W-1:FRAC_BITS] < TWO;
    apply_now             = pend_valid && (!ena || tx_bit_tick);
    next_div              = apply_now ? pend_div : divisor_out;
    next_int              = next_div[CFG_W-1:FRAC_BITS];
  end

  // A divisor swapped in at a bit boundary has already spent one cycle of the
  // new period, hence the reload with int-2 rather than int-1.
  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      base_cnt       <= DEFAULT_INT - ONE;
      frac_acc       <= '0;
      os_phase       <= '0;
      rx_phase       <= '0;
      os_tick        <= 1'b0;
      tx_bit_tick    <= 1'b0;
      rx_sample_tick <= 1'b0;
      divisor_out    <= DEFAULT_DIV;
      pend_div       <= '0;
      pend_valid     <= 1'b0;
      cfg.cfg_ready  <= 1'b1;
      cfg.cfg_err    <= 1'b0;
    end else begin
      cfg.cfg_err <= cfg_fire && cfg_bad;
      if (apply_now) begin
        divisor_out   <= pend_div;
        pend_valid    <= 1'b0;
        cfg.cfg_ready <= 1'b1;
      end else if (cfg_fire && !cfg_bad) begin
        pend_div      <= cfg.cfg_divisor;
        pend_valid    <= 1'b1;
        cfg.cfg_ready <= 1'b0;
      end

      if (!ena) begin
        base_cnt       <= next_int - ONE;
        frac_acc       <= '0;
        os_phase       <= '0;
        rx_phase       <= '0;
        os_tick        <= 1'b0;
        tx_bit_tick    <= 1'b0;
        rx_sample_tick <= 1'b0;
      end else begin
        os_tick        <= tick_now;
        tx_bit_tick    <= tick_now && (os_phase_n == PH_LAST);
        rx_sample_tick <= tick_now && (rx_phase_n == PH_MID);
        os_phase       <= os_phase_n;
        rx_phase       <= rx_phase_n;
        if (apply_now) begin
          base_cnt <= next_int - TWO;
          frac_acc <= '0;
        end else if (tick_now) begin
          base_cnt <= reload_val;
          frac_acc <= acc_sum;
        end else begin
          base_cnt <= base_cnt - ONE;
        end
      end
    end
  end

endmodule
